multicycle_controller: RTL

Multi-cycle control FSM for the fault-tolerant RISC-V core. It sequences fetch, decode, execute, memory and writeback around the instruction decoder's one-hot class flags (is_add, is_load, is_store, is_branch). It drives the PC, instruction register, register file and memory strobes. It traps on malformed decode (zero flags or multiple flags set) and on memory handshake timeouts.

---
 rtl/multicycle_controller.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing around one-hot
// decoder class flags, with traps on malformed decode and memory handshake timeouts.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_add,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_branch,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             trap_clr,
  output logic             imem_req,
  output logic             ir_load,
  output logic             alu_src,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;      // {branch, store, load, add}
  logic [7:0]       wait_q, wait_d;
  logic [7:0]       wait_inc;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [3:0]       flags;

  logic imem_req_c, ir_load_c, alu_src_c, dmem_re_c, dmem_we_c;
  logic reg_we_c, wb_sel_c, pc_en_c, trap_c;
  logic [1:0] pc_src_c;

  assign flags    = {is_branch, is_store, is_load, is_add};
  assign wait_inc = wait_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      op_q      <= 4'd0;
      wait_q    <= 8'd0;
      cause_q   <= 2'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_d     = 8'd0;
    cause_d    = cause_q;
    retired_d  = retired_q;
    imem_req_c = 1'b0;
    ir_load_c  = 1'b0;
    alu_src_c  = 1'b0;
    dmem_re_c  = 1'b0;
    dmem_we_c  = 1'b0;
    reg_we_c   = 1'b0;
    wb_sel_c   = 1'b0;
    pc_en_c    = 1'b0;
    pc_src_c   = 2'd0;
    trap_c     = 1'b0;
    case (state_q)
      StFetch: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_load_c = 1'b1;
          state_d   = StDecode;
        end else if (wait_inc == TimeoutVal) begin
          state_d = StTrap;
          cause_d = 2'd2;
        end else begin
          wait_d = wait_inc;
        end
      end
      StDecode: begin
        op_d = flags;
        if ($countones(flags) != 1) begin
          state_d = StTrap;
          cause_d = 2'd1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (op_q[0]) begin
          state_d = StWb;
        end else if (op_q[1] || op_q[2]) begin
          alu_src_c = 1'b1;
          state_d   = StMem;
        end else if (op_q[3]) begin
          pc_en_c   = 1'b1;
          pc_src_c  = branch_taken ? 2'd1 : 2'd0;
          retired_d = retired_q + 1'b1;
          state_d   = StFetch;
        end else begin
          state_d = StTrap;
          cause_d = 2'd1;
        end
      end
      StMem: begin
        dmem_we_c = op_q[2];
        dmem_re_c = !op_q[2];
        if (dmem_ready) begin
          if (op_q[2]) begin
            pc_en_c   = 1'b1;
            retired_d = retired_q + 1'b1;
            state_d   = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (wait_inc == TimeoutVal) begin
          state_d = StTrap;
          cause_d = 2'd3;
        end else begin
          wait_d = wait_inc;
        end
      end
      StWb: begin
        reg_we_c  = 1'b1;
        wb_sel_c  = op_q[1];
        pc_en_c   = 1'b1;
        retired_d = retired_q + 1'b1;
        state_d   = StFetch;
      end
      StTrap: begin
        trap_c = 1'b1;
        if (trap_clr) begin
          pc_en_c  = 1'b1;
          pc_src_c = 2'd2;
          cause_d  = 2'd0;
          state_d  = StFetch;
        end
      end
      default: begin
        state_d = StTrap;
        cause_d = 2'd1;
      end
    endcase
  end

  // Controls are gated by rst so in-flight strobes drop within the reset cycle.
  assign imem_req   = imem_req_c & ~rst;
  assign ir_load    = ir_load_c & ~rst;
  assign alu_src    = alu_src_c & ~rst;
  assign dmem_re    = dmem_re_c & ~rst;
  assign dmem_we    = dmem_we_c & ~rst;
  assign reg_we     = reg_we_c & ~rst;
  assign wb_sel     = wb_sel_c & ~rst;
  assign pc_en      = pc_en_c & ~rst;
  assign pc_src     = rst ? 2'd0 : pc_src_c;
  assign trap       = trap_c & ~rst;
  assign trap_cause = cause_q;
  assign state      = state_q;
  assign retired    = retired_q;

endmodule
